// File: rtl/io_pkg.sv
// Shared widths and the outbound FIFO entry type for the I/O channel unit.
package io_pkg;
    localparam int IO_CH_W   = 4;
    localparam int IO_DATA_W = 15;
    localparam int IO_NUM_CH = 16;

    typedef struct packed {
        logic [IO_CH_W-1:0]   chan;
        logic [IO_DATA_W-1:0] data;
    } io_entry_t;
endpackage

// File: rtl/io_fifo.sv
// Outbound entry FIFO; pointers carry one extra wrap bit to tell full from empty.
module io_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  io_entry_t push_entry,
    input  logic      pop,
    output io_entry_t head,
    output logic      full,
    output logic      empty,
    output logic      push_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    io_entry_t   mem_q [DEPTH];
    io_entry_t   mem_d [DEPTH];
    logic        pop_ok;
    logic        push_ok;

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign pop_ok    = pop && !empty;
    // When full, a same-cycle pop frees the slot the push is about to land in.
    assign push_ok   = push && (!full || pop_ok);
    assign push_drop = push && !push_ok;
    assign head      = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            mem_d[wptr_q[AW-1:0]] = push_entry;
            wptr_d                = wptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end
endmodule

// File: rtl/io_channel_unit.sv
// I/O channel register file with write bypass, inbound update stream and an
// outbound FIFO of core writes with a sticky overflow flag.
module io_channel_unit
    import io_pkg::*;
#(
    parameter int          NUM_CH     = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] OUT_MASK   = 16'hFFFF,
    parameter logic [15:0] IN_MASK    = 16'hFFFF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 IO_write_en,
    input  logic [IO_CH_W-1:0]   IO_write_sel,
    input  logic [IO_DATA_W-1:0] IO_write_data,
    input  logic [IO_CH_W-1:0]   IO_read_sel,
    output logic [IO_DATA_W-1:0] IO_read_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IO_CH_W-1:0]   out_chan,
    output logic [IO_DATA_W-1:0] out_data,
    input  logic                 in_valid,
    input  logic [IO_CH_W-1:0]   in_chan,
    input  logic [IO_DATA_W-1:0] in_data,
    output logic                 in_ready,
    input  logic                 clear_overflow,
    output logic                 overflow
);
    logic [IO_DATA_W-1:0] ch_q [NUM_CH];
    logic [IO_DATA_W-1:0] ch_d [NUM_CH];
    logic                 overflow_q, overflow_d;
    logic                 collide;
    logic                 in_xfer;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push_drop;
    io_entry_t            push_entry;
    io_entry_t            head;

    assign collide    = IO_write_en && (IO_write_sel == in_chan);
    assign in_ready   = !reset && !collide;
    assign in_xfer    = in_valid && in_ready;
    assign push       = IO_write_en && OUT_MASK[IO_write_sel];
    assign push_entry = '{chan: IO_write_sel, data: IO_write_data};

    assign IO_read_data = (IO_write_en && (IO_write_sel == IO_read_sel)) ? IO_write_data
                                                                         : ch_q[IO_read_sel];
    assign out_valid = !fifo_empty;
    assign out_chan  = head.chan;
    assign out_data  = head.data;
    assign overflow  = overflow_q;

    io_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (out_valid && out_ready),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .push_drop  (push_drop)
    );

    // in_ready already excludes the core's channel, so both writes never hit one register.
    always_comb begin
        ch_d = ch_q;
        if (in_xfer && IN_MASK[in_chan]) ch_d[in_chan] = in_data;
        if (IO_write_en) ch_d[IO_write_sel] = IO_write_data;
    end

    always_comb begin
        overflow_d = overflow_q;
        if (push_drop)           overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
            overflow_q <= 1'b0;
        end else begin
            ch_q       <= ch_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_io_channel_unit.sv
// Directed plus random bench for io_channel_unit against a queue-based reference model.
module tb_io_channel_unit;
    localparam logic [15:0] OUT_MASK_P = 16'hFFEF;
    localparam logic [15:0] IN_MASK_P  = 16'hFFF7;
    localparam int          FD         = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        IO_write_en;
    logic [3:0]  IO_write_sel;
    logic [14:0] IO_write_data;
    logic [3:0]  IO_read_sel;
    logic [14:0] IO_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_chan;
    logic [14:0] out_data;
    logic        in_valid;
    logic [3:0]  in_chan;
    logic [14:0] in_data;
    logic        in_ready;
    logic        clear_overflow;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    logic [14:0] mch [16];
    logic [18:0] mq [$];
    logic        movf;

    io_channel_unit #(
        .NUM_CH(16), .FIFO_DEPTH(FD), .OUT_MASK(OUT_MASK_P), .IN_MASK(IN_MASK_P)
    ) dut (
        .clock(clock), .reset(reset),
        .IO_write_en(IO_write_en), .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
        .IO_read_sel(IO_read_sel), .IO_read_data(IO_read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data),
        .in_valid(in_valid), .in_chan(in_chan), .in_data(in_data), .in_ready(in_ready),
        .clear_overflow(clear_overflow), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        IO_write_en = 0; IO_write_sel = 0; IO_write_data = 0;
        out_ready = 0; in_valid = 0; in_chan = 0; in_data = 0; clear_overflow = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mch[i] = '0;
        mq.delete();
        movf = 1'b0;
    endtask

    // Check combinational outputs for the current inputs, advance the model, then clock once.
    task automatic step();
        logic        col;
        logic        dropped;
        logic [14:0] exp_rd;
        logic [18:0] hd;
        #1;
        col    = IO_write_en && (IO_write_sel == in_chan);
        exp_rd = (IO_write_en && IO_write_sel == IO_read_sel) ? IO_write_data : mch[IO_read_sel];
        chk("read_data", 16'(IO_read_data), 16'(exp_rd));
        chk("in_ready", 16'(in_ready), 16'(!reset && !col));
        chk("out_valid", 16'(out_valid), 16'(mq.size() != 0));
        chk("overflow", 16'(overflow), 16'(movf));
        if (mq.size() != 0) begin
            hd = mq[0];
            chk("out_chan", 16'(out_chan), 16'(hd[18:15]));
            chk("out_data", 16'(out_data), 16'(hd[14:0]));
        end
        dropped = 1'b0;
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (IO_write_en && OUT_MASK_P[IO_write_sel]) begin
            if (mq.size() < FD) mq.push_back({IO_write_sel, IO_write_data});
            else dropped = 1'b1;
        end
        if (dropped) movf = 1'b1;
        else if (clear_overflow) movf = 1'b0;
        if (in_valid && !col && IN_MASK_P[in_chan]) mch[in_chan] = in_data;
        if (IO_write_en) mch[IO_write_sel] = IO_write_data;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wr(input logic [3:0] sel, input logic [14:0] d, input logic rdy);
        idle();
        IO_write_en = 1; IO_write_sel = sel; IO_write_data = d; out_ready = rdy;
        step();
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * FD && mq.size() != 0; k++) begin
            idle();
            out_ready = 1;
            step();
        end
    endtask

    initial begin
        logic [14:0] prev;
        reset = 1;
        idle();
        IO_read_sel = 0;
        model_clear();
        #2;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_overflow", 16'(overflow), 16'd0);
        chk("rst_read", 16'(IO_read_data), 16'd0);
        @(negedge clock);
        reset = 0;

        // bypass
        IO_read_sel = 5;
        idle();
        IO_write_en = 1; IO_write_sel = 5; IO_write_data = 15'o12345;
        #1;
        chk("bypass_same", 16'(IO_read_data), 16'(15'o12345));
        step();
        idle();
        step();
        #1;
        chk("bypass_next", 16'(IO_read_data), 16'(15'o12345));
        drain();

        // stream ordering
        wr(4'd1, 15'd1, 1'b0);
        wr(4'd2, 15'd2, 1'b0);
        wr(4'd1, 15'd3, 1'b0);
        idle();
        #1;
        chk("stream_head_chan", 16'(out_chan), 16'd1);
        chk("stream_head_data", 16'(out_data), 16'd1);
        for (int k = 0; k < 3; k++) begin
            idle();
            out_ready = 1;
            step();
        end
        #1;
        chk("stream_empty", 16'(out_valid), 16'd0);

        // full / overflow
        for (int k = 0; k < 9; k++) wr(4'(k < 4 ? k : k + 1), 15'(100 + k), 1'b0);
        #1;
        chk("full_overflow", 16'(overflow), 16'd1);
        IO_read_sel = 4'd9;
        #1;
        chk("full_ch_updated", 16'(IO_read_data), 16'd108);
        wr(4'd11, 15'd777, 1'b1);
        #1;
        chk("full_pushpop_ovf", 16'(overflow), 16'd1);
        idle();
        clear_overflow = 1;
        step();
        #1;
        chk("ovf_cleared", 16'(overflow), 16'd0);
        drain();

        // collision
        idle();
        IO_read_sel = 7;
        IO_write_en = 1; IO_write_sel = 7; IO_write_data = 15'd200;
        in_valid = 1; in_chan = 7; in_data = 15'd100;
        step();
        IO_write_en = 0;
        step();
        idle();
        #1;
        chk("collision_ch7", 16'(IO_read_data), 16'd100);

        // masks
        prev = mch[3];
        idle();
        in_valid = 1; in_chan = 3; in_data = 15'd55;
        step();
        idle();
        IO_read_sel = 3;
        #1;
        chk("in_mask_ch3", 16'(IO_read_data), 16'(prev));
        drain();
        wr(4'd4, 15'd44, 1'b0);
        idle();
        #1;
        chk("out_mask_ch4", 16'(out_valid), 16'd0);
        step();

        // random traffic
        for (int k = 0; k < 400; k++) begin
            IO_write_en    = 1'($urandom_range(0, 1));
            IO_write_sel   = 4'($urandom_range(0, 15));
            IO_write_data  = 15'($urandom);
            IO_read_sel    = 4'($urandom_range(0, 15));
            out_ready      = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            in_valid       = 1'($urandom_range(0, 1));
            in_chan        = ($urandom_range(0, 1) == 1) ? IO_write_sel : 4'($urandom_range(0, 15));
            in_data        = 15'($urandom);
            clear_overflow = ($urandom_range(0, 15) == 0);
            step();
        end

        // reset mid-stream
        drain();
        wr(4'd6, 15'd61, 1'b0);
        wr(4'd7, 15'd62, 1'b0);
        wr(4'd8, 15'd63, 1'b0);
        idle();
        in_valid = 1; in_chan = 2;
        #2;
        reset = 1;
        #1;
        chk("midrst_out_valid", 16'(out_valid), 16'd0);
        chk("midrst_in_ready", 16'(in_ready), 16'd0);
        model_clear();
        @(negedge clock);
        reset = 0;
        idle();
        for (int c = 0; c < 16; c++) begin
            IO_read_sel = 4'(c);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
